// File: rtl/noc_mcast_pkg.sv
`default_nettype none
// ============================================================================
// Module  : noc_mcast_pkg
// Purpose : Shared definitions for the multicast replication stage. Provides
//           the output port indices, the default header bit positions, the
//           replicator state encoding and a multicast header builder.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package noc_mcast_pkg;

  // Output port indices; port p drives destination mask bit p.
  localparam int P_N = 0;
  localparam int P_E = 1;
  localparam int P_S = 2;
  localparam int P_W = 3;
  localparam int P_L = 4;

  // Default header layout for a 64-bit flit with a 5-port mask.
  localparam int MCAST_FLAG_BIT_DEF = 31;
  localparam int MCAST_MASK_LSB_DEF = 26;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Builds a default-layout multicast header: flag set, mask in the mask
  // field, destination in the low 26 bits, upper bits zero.
  function automatic logic [63:0] mk_mcast_hdr(input logic [4:0]  mask,
                                               input logic [25:0] dest);
    logic [63:0] hdr;
    hdr = '0;
    hdr[25:0] = dest;
    hdr[MCAST_MASK_LSB_DEF +: 5] = mask;
    hdr[MCAST_FLAG_BIT_DEF] = 1'b1;
    return hdr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mcast_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : mcast_sat_counter
// Purpose : Statistics counter that increments on enable and sticks at
//           all-ones instead of wrapping.
// Ports   : clk    - clock
//           rst    - asynchronous active-high reset
//           inc_i  - increment enable
//           cnt_o  - current count
// Rev     : 1.0  initial release
// ============================================================================
module mcast_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/mcast_replicator.sv
`default_nettype none
// ============================================================================
// Module  : mcast_replicator
// Purpose : Captures one flit, derives its destination mask (multicast header
//           field or unicast one-hot) and replicates it to every selected
//           output, either atomically or as a per-port fork.
// Ports   : clk, rst              - clock, asynchronous active-high reset
//           in_flit/in_valid/in_ready - input flit handshake
//           uni_mask              - one-hot route for unicast flits
//           out_flit/out_valid/out_ready - per-port output handshakes
//           busy                  - a flit is held
//           stall_err             - sticky watchdog error
//           mcast_cnt, drop_cnt   - saturating statistics
// Rev     : 1.0  initial release
// ============================================================================
module mcast_replicator
  import noc_mcast_pkg::*;
#(
  parameter int FLIT_W         = 64,
  parameter int NPORTS         = 5,
  parameter int MCAST_FLAG_BIT = MCAST_FLAG_BIT_DEF,
  parameter int MCAST_MASK_LSB = MCAST_MASK_LSB_DEF,
  parameter int ENABLE_MCAST   = 1,
  parameter int CLEAR_ON_SEND  = 1,
  parameter int ATOMIC         = 1,
  parameter int CNT_W          = 16,
  parameter int STALL_LIMIT    = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FLIT_W-1:0]        in_flit,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NPORTS-1:0]        uni_mask,
  output logic [NPORTS*FLIT_W-1:0] out_flit,
  output logic [NPORTS-1:0]        out_valid,
  input  logic [NPORTS-1:0]        out_ready,
  output logic                     busy,
  output logic                     stall_err,
  output logic [CNT_W-1:0]         mcast_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int                 STALL_W   = $clog2(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

  state_e              state_q, state_d;
  logic [FLIT_W-1:0]   hold_q, hold_d;
  logic [NPORTS-1:0]   pend_q, pend_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic                err_q, err_d;

  logic                is_mc;
  logic [NPORTS-1:0]   sel_mask;
  logic [NPORTS-1:0]   fire;
  logic                hold_st;
  logic                done;
  logic                accept;
  logic                mc_inc;
  logic                drop_inc;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    pend_d    = pend_q;
    stall_d   = stall_q;
    err_d     = err_q;
    out_valid = '0;

    is_mc    = (ENABLE_MCAST != 0) && in_flit[MCAST_FLAG_BIT];
    sel_mask = is_mc ? in_flit[MCAST_MASK_LSB +: NPORTS] : uni_mask;
    hold_st  = (state_q == ST_HOLD);

    // Atomic issue waits until every pending port is ready at once, so a
    // partial transfer can never happen.
    if (hold_st) begin
      if (ATOMIC != 0) begin
        out_valid = (&(out_ready | ~pend_q)) ? pend_q : '0;
      end else begin
        out_valid = pend_q;
      end
    end

    fire     = out_valid & out_ready;
    done     = hold_st && ((pend_q & ~fire) == '0);
    in_ready = !hold_st || done;
    accept   = in_valid && in_ready;
    mc_inc   = accept && is_mc && (sel_mask != '0);
    drop_inc = accept && (sel_mask == '0);

    if (hold_st) begin
      pend_d = pend_q & ~fire;
      if (done) begin
        state_d = ST_IDLE;
        stall_d = '0;
      end else if (stall_q != STALL_MAX) begin
        stall_d = stall_q + STALL_W'(1);
      end
    end
    if (stall_d == STALL_MAX) begin
      err_d = 1'b1;
    end

    // A new flit replaces the finished one in the same cycle (full rate).
    if (accept && (sel_mask != '0)) begin
      state_d = ST_HOLD;
      pend_d  = sel_mask;
      hold_d  = in_flit;
      if ((CLEAR_ON_SEND != 0) && is_mc) begin
        hold_d[MCAST_FLAG_BIT] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      pend_q  <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign out_flit  = {NPORTS{hold_q}};
  assign busy      = (state_q == ST_HOLD);
  assign stall_err = err_q;

  mcast_sat_counter #(.CNT_W(CNT_W)) u_mcast_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (mc_inc),
    .cnt_o (mcast_cnt)
  );

  mcast_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (drop_inc),
    .cnt_o (drop_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_mcast_replicator.sv
`default_nettype none
// ============================================================================
// Module  : tb_mcast_replicator
// Purpose : Self-checking bench driving an atomic and a forked replicator
//           with the same stimulus; each has its own scoreboard and model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mcast_replicator;
  import noc_mcast_pkg::*;

  localparam int FW = 64;
  localparam int NP = 5;
  localparam int CW = 4;
  localparam int SL = 8;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [FW-1:0] flit;
    logic [NP-1:0] mask;
  } item_t;

  logic          clk;
  logic          rst;
  logic [FW-1:0] in_flit;
  logic          in_valid;
  logic [NP-1:0] uni_mask;
  logic [NP-1:0] out_ready;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int AT = (g == 0) ? 1 : 0;

    logic             in_ready;
    logic [NP*FW-1:0] out_flit;
    logic [NP-1:0]    out_valid;
    logic             busy;
    logic             stall_err;
    logic [CW-1:0]    mcast_cnt;
    logic [CW-1:0]    drop_cnt;

    mcast_replicator #(
      .FLIT_W(FW), .NPORTS(NP), .MCAST_FLAG_BIT(31), .MCAST_MASK_LSB(26),
      .ENABLE_MCAST(1), .CLEAR_ON_SEND(1), .ATOMIC(AT), .CNT_W(CW),
      .STALL_LIMIT(SL)
    ) u_dut (
      .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid),
      .in_ready(in_ready), .uni_mask(uni_mask), .out_flit(out_flit),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
      .stall_err(stall_err), .mcast_cnt(mcast_cnt), .drop_cnt(drop_cnt)
    );

    // Reference model: a queue of expected copies plus the set of ports
    // still owed a copy of the head item.
    item_t         q[$];
    logic [NP-1:0] rem;
    int            stall_run;
    bit            exp_err;
    int            exp_mc;
    int            exp_drop;

    always @(negedge clk) begin : p_mon
      logic [NP-1:0] ev;
      logic [NP-1:0] m;
      logic [FW-1:0] f;
      bit            done;
      bit            exp_rdy;
      bit            mc;
      if (rst) begin
        chk(out_valid == '0, "rst_out_valid", 64'(out_valid), 64'd0);
        chk(out_flit == '0, "rst_out_flit", out_flit[63:0], 64'd0);
        chk(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
        chk(stall_err == 1'b0, "rst_stall_err", 64'(stall_err), 64'd0);
        chk(mcast_cnt == '0 && drop_cnt == '0, "rst_counters",
            64'({mcast_cnt, drop_cnt}), 64'd0);
        q.delete();
        rem = '0;
        stall_run = 0;
        exp_err = 1'b0;
        exp_mc = 0;
        exp_drop = 0;
      end else begin
        chk(busy == (q.size() != 0), "busy", 64'(busy), 64'(q.size() != 0));
        chk(stall_err == exp_err, "stall_err", 64'(stall_err), 64'(exp_err));
        chk(int'(mcast_cnt) == exp_mc, "mcast_cnt", 64'(mcast_cnt), 64'(exp_mc));
        chk(int'(drop_cnt) == exp_drop, "drop_cnt", 64'(drop_cnt), 64'(exp_drop));

        ev = '0;
        done = 1'b0;
        if (q.size() != 0) begin
          if (AT != 0) ev = ((out_ready & rem) == rem) ? rem : '0;
          else         ev = rem;
          done = ((rem & ~(ev & out_ready)) == '0);
        end
        chk(out_valid == ev, "out_valid", 64'(out_valid), 64'(ev));
        if (ev != '0) begin
          for (int p = 0; p < NP; p++) begin
            if (ev[p]) chk(out_flit[p*FW +: FW] == q[0].flit, "out_flit",
                           out_flit[p*FW +: FW], q[0].flit);
          end
        end
        exp_rdy = (q.size() == 0) || done;
        chk(in_ready == exp_rdy, "in_ready", 64'(in_ready), 64'(exp_rdy));

        if (q.size() != 0) begin
          rem = rem & ~(ev & out_ready);
          if (done) begin
            void'(q.pop_front());
            stall_run = 0;
          end else begin
            stall_run++;
            if (stall_run >= SL) exp_err = 1'b1;
          end
        end

        if (in_valid && exp_rdy) begin
          mc = in_flit[31];
          m  = mc ? in_flit[30:26] : uni_mask;
          if (m == '0) begin
            if (exp_drop < CMAX) exp_drop++;
          end else begin
            f = in_flit;
            if (mc) begin
              f[31] = 1'b0;
              if (exp_mc < CMAX) exp_mc++;
            end
            q.push_back('{flit: f, mask: m});
            rem = m;
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [FW-1:0] f, input logic [NP-1:0] u);
    in_flit  = f;
    uni_mask = u;
    in_valid = 1'b1;
    cyc(1);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [FW-1:0] hdr;
    int            p;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_flit   = '0;
    uni_mask  = '0;
    out_ready = '1;
    cyc(3);
    rst = 1'b0;
    cyc(2);

    // E+L multicast, all ready.
    hdr = mk_mcast_hdr(5'b10010, 26'h0ABCDE) | {32'hDEAD_BEEF, 32'h0};
    send(hdr, 5'b00000);
    cyc(3);

    // Same flit, L not ready for three cycles.
    out_ready = 5'b01111;
    send(hdr, 5'b00000);
    cyc(3);
    out_ready = '1;
    cyc(3);

    // N,E,S with staggered readiness.
    out_ready = '0;
    send(mk_mcast_hdr(5'b00111, 26'h1234567), 5'b00000);
    out_ready = 5'b00001; cyc(1);
    out_ready = 5'b00010; cyc(1);
    out_ready = 5'b00000; cyc(1);
    out_ready = 5'b00100; cyc(1);
    out_ready = '1;
    cyc(3);

    // Unicast to W, then a zero-mask multicast drop.
    send(64'h0123_4567_7FFF_FFFF, 5'b01000);
    cyc(2);
    send(mk_mcast_hdr(5'b00000, 26'h0000055), 5'b00001);
    cyc(2);

    // Stall watchdog, then reset while holding.
    out_ready = '0;
    send(mk_mcast_hdr(5'b00001, 26'h0000077), 5'b00000);
    cyc(12);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    out_ready = '1;
    cyc(4);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_flit   = {$urandom, $urandom};
      p         = $urandom_range(0, 5);
      uni_mask  = (p == 5) ? 5'b00000 : 5'(1 << p);
      out_ready = 5'($urandom | $urandom);
      if ($urandom_range(0, 199) == 0) out_ready = '0;
      rst       = ($urandom_range(0, 999) == 0);
      cyc(1);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = '1;
    cyc(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
